// File: rtl/encoder_64b66b_if.sv
// rtl/encoder_64b66b_if.sv - input word stream and output block stream of the 64b/66b encoder
interface encoder_64b66b_if;
    logic [1:0]  s_axis_ttype;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [65:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    // Word source and block sink (bench / surrounding logic)
    modport master (
        output s_axis_ttype, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    // Encoder view
    modport slave (
        input  s_axis_ttype, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/encoder_64b66b.sv
// rtl/encoder_64b66b.sv - 64b/66b transmit encoder with sync header and x^58+x^39+1 scrambler
module encoder_64b66b #(
    parameter bit          SCRAMBLER_EN = 1'b1,
    parameter logic [57:0] SCR_SEED     = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    encoder_64b66b_if.slave  axis,
    output logic             err_illegal_type,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [63:0] ERR_PAYLOAD = {{8{7'h1E}}, 8'h1E};

    logic             r_m_tvalid;
    logic [65:0]      r_m_tdata;
    logic [57:0]      r_scr;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_illegal;
    logic [1:0]       w_hdr;
    logic [63:0]      w_d;
    logic [63:0]      w_y;
    logic [57:0]      w_scr_next;

    assign axis.s_axis_tready = reset_n && (!r_m_tvalid || axis.m_axis_tready);
    assign w_accept           = axis.s_axis_tvalid && axis.s_axis_tready;

    assign axis.m_axis_tvalid = r_m_tvalid;
    assign axis.m_axis_tdata  = r_m_tdata;
    assign err_illegal_type   = r_err;
    assign illegal_cnt        = r_cnt;

    // Header selection; illegal types are replaced by an error control block
    always_comb begin
        w_illegal = (axis.s_axis_ttype == 2'b00) || (axis.s_axis_ttype == 2'b11);
        w_hdr     = w_illegal ? 2'b10 : axis.s_axis_ttype;
        w_d       = w_illegal ? ERR_PAYLOAD : axis.s_axis_tdata;
    end

    // Parallel scrambler: ext[57:0] holds past line bits oldest-first, ext[121:58] the new block
    always_comb begin
        logic [121:0] v_ext;
        v_ext = '0;
        for (int k = 0; k < 58; k++) begin
            v_ext[57-k] = r_scr[k];
        end
        for (int i = 0; i < 64; i++) begin
            v_ext[i+58] = w_d[i] ^ v_ext[i+19] ^ v_ext[i];
        end
        for (int k = 0; k < 58; k++) begin
            w_scr_next[k] = v_ext[121-k];
        end
        w_y = SCRAMBLER_EN ? v_ext[121:58] : w_d;
    end

    // Output register, scrambler state and illegal-type accounting
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_scr      <= SCR_SEED;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_err <= w_accept && w_illegal;
            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= {w_y, w_hdr};
                if (SCRAMBLER_EN) begin
                    r_scr <= w_scr_next;
                end
                if (w_illegal && !(&r_cnt)) begin
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (axis.m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_encoder_64b66b.sv
// tb/tb_encoder_64b66b.sv - scoreboard bench for encoder_64b66b against a bit-serial reference
module tb_encoder_64b66b;
    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ERRP = {{8{7'h1E}}, 8'h1E};

    logic clk;
    logic ra_n, rb_n;
    logic        a_err, b_err;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    encoder_64b66b_if ifa ();
    encoder_64b66b_if ifb ();

    encoder_64b66b #(.SCRAMBLER_EN(1'b1), .SCR_SEED(SEED), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(ra_n), .axis(ifa), .err_illegal_type(a_err), .illegal_cnt(a_cnt));

    encoder_64b66b #(.SCRAMBLER_EN(1'b0), .SCR_SEED(SEED), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(rb_n), .axis(ifb), .err_illegal_type(b_err), .illegal_cnt(b_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [65:0] sb_q[$];
    logic [57:0] m_hist;
    int          m_cnt;
    logic        exp_err;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain line-order scrambler, one bit at a time; m_hist[k] = bit sent k+1 bits ago
    task automatic model_accept(input logic [1:0] tt, input logic [63:0] d);
        logic [63:0] p;
        logic [63:0] y;
        logic [1:0]  h;
        bit          bad;
        bad = (tt == 2'b00) || (tt == 2'b11);
        h   = bad ? 2'b10 : tt;
        p   = bad ? ERRP : d;
        for (int i = 0; i < 64; i++) begin
            y[i]   = p[i] ^ m_hist[38] ^ m_hist[57];
            m_hist = {m_hist[56:0], y[i]};
        end
        sb_q.push_back({y, h});
        exp_err = bad;
        if (bad && m_cnt < 65535) m_cnt++;
    endtask

    // One cycle on DUT A: check last edge's err/cnt, present inputs, record acceptance
    task automatic drive_a(input bit v, input logic [1:0] tt, input logic [63:0] d,
                           input bit rdy, output bit acc);
        @(negedge clk);
        #1;
        chk("a_err_illegal_type", {65'd0, a_err}, {65'd0, exp_err});
        chk("a_illegal_cnt", {50'd0, a_cnt}, 66'(m_cnt));
        ifa.s_axis_tvalid = v;
        ifa.s_axis_ttype  = tt;
        ifa.s_axis_tdata  = d;
        ifa.m_axis_tready = rdy;
        #1;
        acc = v && ifa.s_axis_tready;
        if (acc) model_accept(tt, d);
        else     exp_err = 1'b0;
    endtask

    task automatic a_reset(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            ra_n = 1'b0;
            ifa.s_axis_tvalid = 1'b0;
            #1;
            chk("a_s_tready_in_reset", {65'd0, ifa.s_axis_tready}, 66'd0);
            @(negedge clk);
            #2;
            chk("a_m_tvalid_reset", {65'd0, ifa.m_axis_tvalid}, 66'd0);
            chk("a_m_tdata_reset", ifa.m_axis_tdata, 66'd0);
            chk("a_cnt_reset", {50'd0, a_cnt}, 66'd0);
            chk("a_err_reset", {65'd0, a_err}, 66'd0);
        end
        sb_q.delete();
        m_hist  = SEED;
        m_cnt   = 0;
        exp_err = 1'b0;
        ra_n    = 1'b1;
    endtask

    // Monitor: pops expected block on every output handshake, checks hold stability
    logic [65:0] held_data;
    bit          held;
    initial held = 0;
    always begin
        @(negedge clk);
        #3;
        if (!ra_n || ifa.m_axis_tvalid !== 1'b1) begin
            held = 0;
        end else begin
            if (held) chk("a_m_tdata_stable", ifa.m_axis_tdata, held_data);
            if (ifa.m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    chk("a_unexpected_block", ifa.m_axis_tdata, 66'h0);
                    checks++; errors++;
                    $display("FAIL a_unexpected_block: got %h expected no output", ifa.m_axis_tdata);
                end else begin
                    chk("a_block", ifa.m_axis_tdata, sb_q.pop_front());
                end
                held = 0;
            end else begin
                chk("a_s_tready_stall", {65'd0, ifa.s_axis_tready}, 66'd0);
                held_data = ifa.m_axis_tdata;
                held = 1;
            end
        end
    end

    // One cycle on DUT B (tready always 1); returns #1 after the edge
    task automatic b_cycle(input bit v, input logic [1:0] tt, input logic [63:0] d);
        @(negedge clk);
        #1;
        ifb.s_axis_tvalid = v;
        ifb.s_axis_ttype  = tt;
        ifb.s_axis_tdata  = d;
        ifb.m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          acc;
        logic [63:0] w[4];
        logic [63:0] cur_d;
        logic [1:0]  cur_t;
        bit          cur_v;
        int          idx, done, cyc;
        int          exp_b[5] = '{1, 2, 3, 3, 3};

        ra_n = 1'b0; rb_n = 1'b0;
        ifa.s_axis_tvalid = 0; ifa.s_axis_ttype = 0; ifa.s_axis_tdata = 0; ifa.m_axis_tready = 0;
        ifb.s_axis_tvalid = 0; ifb.s_axis_ttype = 0; ifb.s_axis_tdata = 0; ifb.m_axis_tready = 1;
        m_hist = SEED; m_cnt = 0; exp_err = 0;

        // DUT B: unscrambled path and narrow saturating counter
        repeat (2) @(posedge clk);
        #1;
        chk("b_m_tvalid_reset", {65'd0, ifb.m_axis_tvalid}, 66'd0);
        chk("b_cnt_reset", {64'd0, b_cnt}, 66'd0);
        @(negedge clk);
        rb_n = 1'b1;
        b_cycle(1, 2'b01, 64'h0123_4567_89AB_CDEF);
        chk("b_plain_block", ifb.m_axis_tdata, {64'h0123_4567_89AB_CDEF, 2'b01});
        chk("b_plain_valid", {65'd0, ifb.m_axis_tvalid}, 66'd1);
        b_cycle(0, 2'b01, 64'h0);
        chk("b_valid_one_cycle", {65'd0, ifb.m_axis_tvalid}, 66'd0);
        for (int k = 0; k < 5; k++) begin
            b_cycle(1, (k % 2) ? 2'b11 : 2'b00, 64'(k) * 64'h1111);
            chk("b_err_block", ifb.m_axis_tdata, {ERRP, 2'b10});
            chk("b_err_pulse", {65'd0, b_err}, 66'd1);
            chk("b_cnt_sat", {64'd0, b_cnt}, 66'(exp_b[k]));
        end
        b_cycle(0, 2'b00, 64'h0);
        chk("b_err_clear", {65'd0, b_err}, 66'd0);
        chk("b_cnt_hold", {64'd0, b_cnt}, 66'd3);

        // DUT A: reset, then backpressure burst of 4 words
        a_reset(2);
        for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            if (idx < 4) drive_a(1, 2'b01, w[idx], !(c >= 1 && c <= 5), acc);
            else         drive_a(0, 2'b01, 64'h0, 1, acc);
            if (acc) idx++;
        end
        chk("a_burst_all_accepted", 66'(idx), 66'd4);

        // Random traffic with random valid/ready
        done = 0; cyc = 0; cur_v = 0; cur_d = '0; cur_t = 2'b01;
        while (done < 1000 && cyc < 6000) begin
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = {$urandom, $urandom};
                cur_t = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
            end
            drive_a(cur_v, cur_t, cur_d, $urandom_range(0, 9) < 7, acc);
            if (acc) begin done++; cur_v = 0; end
            else if (cur_v && $urandom_range(0, 7) == 0) cur_v = 0;
            cyc++;
        end
        chk("a_random_words_done", 66'(done), 66'd1000);

        // Reset mid-stream while an output block is held
        drive_a(0, 2'b01, 64'h0, 1, acc);
        drive_a(0, 2'b01, 64'h0, 1, acc);
        drive_a(1, 2'b00, {$urandom, $urandom}, 0, acc);
        chk("a_pre_reset_accept", {65'd0, acc}, 66'd1);
        drive_a(0, 2'b01, 64'h0, 0, acc);
        a_reset(2);
        for (int k = 0; k < 20; k++) drive_a(1, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1, acc);
        repeat (4) drive_a(0, 2'b01, 64'h0, 1, acc);
        chk("a_scoreboard_drained", 66'(sb_q.size()), 66'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
